// File: rtl/ysyx_22050019_mux_cam.sv
// ysyx_22050019_mux_cam: runtime-programmable key/value CAM with a registered, handshaked lookup port
module ysyx_22050019_mux_cam #(
  parameter int NR_KEY = 8,
  parameter int KEY_LEN = 8,
  parameter int DATA_LEN = 32,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_vld,
  input  logic                clr_all,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);
  logic [NR_KEY-1:0]   vld;
  logic [KEY_LEN-1:0]  key [NR_KEY];
  logic [DATA_LEN-1:0] dat [NR_KEY];
  logic                m_hit;
  logic [IDX_W-1:0]    m_idx;
  logic [DATA_LEN-1:0] m_data;
  logic                req_fire;
  logic                rsp_fire;
  assign req_ready = !rsp_valid || rsp_ready;
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  // scan from the top so the lowest matching entry is the last to win
  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_data = default_out;
    for (int i = NR_KEY - 1; i >= 0; i--)
      if (vld[i] && key[i] == req_key) begin
        m_hit  = 1'b1;
        m_idx  = IDX_W'(i);
        m_data = dat[i];
      end
  end
  // a write to an entry overrides a same-cycle clear of that entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key[i] <= '0;
        dat[i] <= '0;
      end
    end else
      for (int i = 0; i < NR_KEY; i++)
        if (wr_en && wr_idx == IDX_W'(i)) begin
          vld[i] <= wr_vld;
          key[i] <= wr_key;
          dat[i] <= wr_data;
        end else if (clr_all)
          vld[i] <= 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
    end else begin
      if (req_fire) begin
        rsp_data <= m_data;
        rsp_hit  <= m_hit;
        rsp_idx  <= m_idx;
      end
      if (req_fire) rsp_valid <= 1'b1;
      else if (rsp_fire) rsp_valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (rsp_fire && rsp_hit && ~&hit_cnt) hit_cnt <= hit_cnt + CNT_W'(1);
      if (rsp_fire && !rsp_hit && ~&miss_cnt) miss_cnt <= miss_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_ysyx_22050019_mux_cam.sv
// tb_ysyx_22050019_mux_cam: vector table plus scoreboard bench for the lookup CAM
module tb_ysyx_22050019_mux_cam;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        wr_en = 0, wr_vld = 0, clr_all = 0;
  logic [2:0]  wr_idx = 0;
  logic [7:0]  wr_key = 0, req_key = 0;
  logic [31:0] wr_data = 0, default_out = 0;
  logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, rsp_hit;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_idx;
  logic [3:0]  hit_cnt, miss_cnt;
  typedef struct {logic h; logic [2:0] i; logic [31:0] d;} exp_t;
  typedef struct {
    logic we; logic [2:0] wi; logic [7:0] wk; logic [31:0] wd; logic wv; logic clr;
    logic rv; logic [7:0] rk; logic [31:0] dflt; logic eh; logic [2:0] ei; logic [31:0] ed;
  } vec_t;
  exp_t       q[$];
  exp_t       nxt;
  vec_t       vt[$];
  logic [3:0] m_hit = 0, m_miss = 0;
  int         total = 0, bad = 0;

  ysyx_22050019_mux_cam #(.NR_KEY(8), .KEY_LEN(8), .DATA_LEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .wr_vld(wr_vld), .clr_all(clr_all), .req_valid(req_valid),
    .req_ready(req_ready), .req_key(req_key), .default_out(default_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .rsp_idx(rsp_idx), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endfunction

  task automatic set_req(logic v, logic [7:0] k, logic [31:0] d, logic eh, logic [2:0] ei, logic [31:0] ed);
    req_valid = v; req_key = k; default_out = d;
    nxt = '{eh, ei, ed};
  endtask

  // scoreboard: push on request fire, pop and compare on response fire
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_hit = 0;
      m_miss = 0;
    end else begin
      chk("hit_cnt", hit_cnt, m_hit);
      chk("miss_cnt", miss_cnt, m_miss);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_hit", rsp_hit, e.h);
          chk("rsp_idx", rsp_idx, e.i);
          if (e.h) m_hit = (m_hit == 4'hf) ? m_hit : m_hit + 1;
          else m_miss = (m_miss == 4'hf) ? m_miss : m_miss + 1;
        end
      end
      if (req_valid && req_ready) q.push_back(nxt);
    end
  end

  initial begin
    vt.push_back('{0,0,8'h00,0,0,0, 1,8'h00,32'hDEADBEEF, 0,0,32'hDEADBEEF});
    vt.push_back('{1,3,8'h5A,32'h12345678,1,0, 0,0,0, 0,0,0});
    vt.push_back('{0,0,0,0,0,0, 1,8'h5A,32'h0, 1,3,32'h12345678});
    vt.push_back('{1,2,8'h11,32'hA,1,0, 0,0,0, 0,0,0});
    vt.push_back('{1,6,8'h11,32'hB,1,0, 0,0,0, 0,0,0});
    vt.push_back('{0,0,0,0,0,0, 1,8'h11,32'h0, 1,2,32'hA});
    vt.push_back('{1,2,8'h11,32'hA,0,0, 0,0,0, 0,0,0});
    vt.push_back('{0,0,0,0,0,0, 1,8'h11,32'h0, 1,6,32'hB});
    vt.push_back('{1,0,8'h77,32'h77,1,0, 1,8'h77,32'h5555, 0,0,32'h5555});
    vt.push_back('{0,0,0,0,0,0, 1,8'h77,32'h0, 1,0,32'h77});
    vt.push_back('{0,0,0,0,0,0, 1,8'h11,32'h0, 1,6,32'hB});
    vt.push_back('{1,5,8'h33,32'hC0FFEE,1,1, 0,0,0, 0,0,0});
    vt.push_back('{0,0,0,0,0,0, 1,8'h5A,32'h1, 0,0,32'h1});
    vt.push_back('{0,0,0,0,0,0, 1,8'h33,32'h0, 1,5,32'hC0FFEE});
    vt.push_back('{0,0,0,0,0,0, 1,8'h11,32'h2, 0,0,32'h2});
    vt.push_back('{0,0,0,0,0,0, 1,8'h77,32'h3, 0,0,32'h3});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_idx", rsp_idx, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst_n = 1;
    foreach (vt[n]) begin
      @(posedge clk);
      #1;
      wr_en = vt[n].we; wr_idx = vt[n].wi; wr_key = vt[n].wk;
      wr_data = vt[n].wd; wr_vld = vt[n].wv; clr_all = vt[n].clr;
      set_req(vt[n].rv, vt[n].rk, vt[n].dflt, vt[n].eh, vt[n].ei, vt[n].ed);
    end
    @(posedge clk);
    #1;
    wr_en = 0; clr_all = 0;
    set_req(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 0;
    set_req(1, 8'h33, 32'h0, 1, 5, 32'hC0FFEE);
    @(posedge clk);
    #1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 32'hC0FFEE);
      chk("bp_rsp_hit", rsp_hit, 1);
      chk("bp_rsp_idx", rsp_idx, 5);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("b2b_rsp_valid", rsp_valid, 1);
      chk("b2b_req_ready", req_ready, 1);
    end
    @(posedge clk);
    #1;
    set_req(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 0;
    set_req(1, 8'h33, 32'h0, 1, 5, 32'hC0FFEE);
    @(posedge clk);
    #1;
    set_req(0, 0, 0, 0, 0, 0);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_hit_cnt", hit_cnt, 0);
    chk("mid_rst_miss_cnt", miss_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    rsp_ready = 1;
    for (int k = 0; k < 19; k++) begin
      @(posedge clk);
      #1;
      set_req(1, 8'h33, 32'h0BAD0000 + k, 0, 0, 32'h0BAD0000 + k);
    end
    @(posedge clk);
    #1;
    set_req(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    chk("drain", q.size(), 0);
    @(negedge clk);
    chk("sat_miss_cnt", miss_cnt, 4'hf);
    chk("sat_hit_cnt", hit_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
